adaptive_delta_mod: RTL and testbench

Parametrised adaptive delta modulator integrator. It is the next generation of the team's saturating up/down counter: the comparator decision now moves the accumulator by an adaptive step of 2^shift instead of ±1. The shift grows on runs of identical decisions and shrinks on decision reversals, in CVSD style. The block sits between the analog comparator input and the feedback DAC word, is advanced only on a sample strobe, and exports the decision bitstream.

---
 rtl/adm_pkg.sv | 68 ++++++
 rtl/adm_step_ctrl.sv | 100 ++++++++++
 rtl/adaptive_delta_mod.sv | 105 ++++++++++
 tb/tb_adaptive_delta_mod.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/adm_pkg.sv
// adm_pkg: shared definitions for the adaptive delta modulator.
//   - ADM_MAX_W        : widest accumulator the clamp helpers support.
//   - adm_shift_w()    : width of the step-exponent field for a given MAX_SHIFT.
//   - adm_clamp_addsub : saturating add/sub of an adaptive step, result value.
//   - adm_clamp_hit    : companion flag, 1 when the clamp altered the result.
// The clamp helpers work on zero-extended operands, with one guard bit above
// ADM_MAX_W. The width of the real accumulator is passed in as an argument,
// so a single pair of functions serves any WIDTH up to ADM_MAX_W.
package adm_pkg;

   localparam int ADM_MAX_W         = 32;
   localparam int ADM_DEF_MAX_SHIFT = 4;

   localparam logic [ADM_MAX_W-1:0] ADM_ONE   = {{(ADM_MAX_W-1){1'b0}}, 1'b1};
   localparam logic [ADM_MAX_W:0]   ADM_ONE_X = {{ADM_MAX_W{1'b0}}, 1'b1};

   // Step exponent runs 0..max_shift, so it needs clog2(max_shift+1) bits.
   function automatic int adm_shift_w(input int max_shift);
      return $clog2(max_shift + 1);
   endfunction

   localparam int ADM_DEF_SHIFT_W = adm_shift_w(ADM_DEF_MAX_SHIFT);

   // Largest value representable in w bits, held in the guarded width.
   function automatic logic [ADM_MAX_W:0] adm_ext_max(input int w);
      return (ADM_ONE_X << w) - ADM_ONE_X;
   endfunction

   // Saturating acc +/- step inside [0, 2^w-1].
   function automatic logic [ADM_MAX_W-1:0] adm_clamp_addsub(
      input logic [ADM_MAX_W-1:0] acc,
      input logic [ADM_MAX_W-1:0] step,
      input logic                 up,
      input int                   w
   );
      logic [ADM_MAX_W:0] sum;
      logic [ADM_MAX_W:0] lim;
      logic [ADM_MAX_W:0] res;
      lim = adm_ext_max(w);
      sum = {1'b0, acc} + {1'b0, step};
      if (up) begin
         res = (sum > lim) ? lim : sum;
      end else begin
         res = (step > acc) ? {(ADM_MAX_W+1){1'b0}} : ({1'b0, acc} - {1'b0, step});
      end
      return res[ADM_MAX_W-1:0];
   endfunction

   // 1 when the unclamped result would fall outside [0, 2^w-1]. Landing exactly
   // on a bound does not count, but sitting on a bound and pushing further does.
   function automatic logic adm_clamp_hit(
      input logic [ADM_MAX_W-1:0] acc,
      input logic [ADM_MAX_W-1:0] step,
      input logic                 up,
      input int                   w
   );
      logic [ADM_MAX_W:0] sum;
      logic               hit;
      sum = {1'b0, acc} + {1'b0, step};
      if (up) begin
         hit = (sum > adm_ext_max(w));
      end else begin
         hit = (step > acc);
      end
      return hit;
   endfunction

endpackage

// File: rtl/adm_step_ctrl.sv
// adm_step_ctrl: CVSD-style step-exponent controller.
// Tracks the previous decision, the length of the current run of identical
// decisions (saturating at RUN_LEN) and the step exponent.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   sample_en_i  : state advances only when 1
//   d_i          : comparator decision of this sample
//   adapt_en_i   : 0 forces the exponent to 0 (fixed step of 1)
//   shift_n_o    : exponent to use for this sample (combinational, internal use)
//   shift_q_o    : registered exponent of the last sample
module adm_step_ctrl
   import adm_pkg::*;
#(
   parameter  int RUN_LEN   = 3,
   parameter  int MAX_SHIFT = 4,
   localparam int SHIFT_W   = adm_shift_w(MAX_SHIFT),
   localparam int RUN_W     = $clog2(RUN_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sample_en_i,
   input  logic               d_i,
   input  logic               adapt_en_i,
   output logic [SHIFT_W-1:0] shift_n_o,
   output logic [SHIFT_W-1:0] shift_q_o
);

   localparam logic [RUN_W-1:0]   RUN_ZERO   = RUN_W'(1'b0);
   localparam logic [RUN_W-1:0]   RUN_ONE    = RUN_W'(1'b1);
   localparam logic [RUN_W-1:0]   RUN_MAX    = RUN_W'(RUN_LEN);
   localparam logic [SHIFT_W-1:0] SHIFT_ZERO = SHIFT_W'(1'b0);
   localparam logic [SHIFT_W-1:0] SHIFT_ONE  = SHIFT_W'(1'b1);
   localparam logic [SHIFT_W-1:0] SHIFT_MAX  = SHIFT_W'(MAX_SHIFT);

   logic               prev_q,    prev_d;
   logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
   logic [SHIFT_W-1:0] shift_q,   shift_d;
   logic               same_s;
   logic [RUN_W-1:0]   run_nxt_s;
   logic [SHIFT_W-1:0] shift_nxt_s;

   // Candidate run length and exponent for a sample taken this cycle.
   always_comb begin
      same_s      = (d_i == prev_q);
      run_nxt_s   = RUN_ONE;
      shift_nxt_s = shift_q;

      if (!same_s) begin
         run_nxt_s = RUN_ONE;
      end else if (run_cnt_q == RUN_MAX) begin
         run_nxt_s = RUN_MAX;
      end else begin
         run_nxt_s = run_cnt_q + RUN_ONE;
      end

      // A full run grows the step before a reversal can shrink it.
      if (!adapt_en_i) begin
         shift_nxt_s = SHIFT_ZERO;
      end else if (run_nxt_s == RUN_MAX) begin
         shift_nxt_s = (shift_q == SHIFT_MAX) ? SHIFT_MAX : (shift_q + SHIFT_ONE);
      end else if (!same_s) begin
         shift_nxt_s = (shift_q == SHIFT_ZERO) ? SHIFT_ZERO : (shift_q - SHIFT_ONE);
      end else begin
         shift_nxt_s = shift_q;
      end
   end

   // Commit the candidates only on a sample strobe.
   always_comb begin
      prev_d    = prev_q;
      run_cnt_d = run_cnt_q;
      shift_d   = shift_q;
      if (sample_en_i) begin
         prev_d    = d_i;
         run_cnt_d = run_nxt_s;
         shift_d   = shift_nxt_s;
      end else begin
         prev_d    = prev_q;
         run_cnt_d = run_cnt_q;
         shift_d   = shift_q;
      end
   end

   // Controller state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q    <= 1'b0;
         run_cnt_q <= RUN_ZERO;
         shift_q   <= SHIFT_ZERO;
      end else begin
         prev_q    <= prev_d;
         run_cnt_q <= run_cnt_d;
         shift_q   <= shift_d;
      end
   end

   assign shift_n_o = shift_nxt_s;
   assign shift_q_o = shift_q;

endmodule

// File: rtl/adaptive_delta_mod.sv
// adaptive_delta_mod: adaptive delta modulator integrator.
// On each sample strobe the comparator decision moves the accumulator up or
// down by 2^shift, saturating at 0 and 2^WIDTH-1. The exponent adapts to runs
// and reversals of the decision. With adapt_en=0 the step is 1, which is the
// behaviour of the older saturating up/down counter.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   sample_en   : sample strobe, state advances only when 1
//   comp_res    : comparator decision (1 = count up)
//   adapt_en    : 1 = adaptive step, 0 = fixed step of 1
//   counter     : accumulator, drives the feedback DAC
//   step_shift  : step exponent used by the last sample
//   bit_out     : registered decision of the last sample
//   bit_valid   : one-cycle pulse after each sample
//   sat         : one-cycle pulse when the last update was clamped
// WIDTH must not exceed adm_pkg::ADM_MAX_W.
module adaptive_delta_mod
   import adm_pkg::*;
#(
   parameter  int          WIDTH     = 8,
   parameter  int          RUN_LEN   = 3,
   parameter  int          MAX_SHIFT = 4,
   parameter  int unsigned INIT      = 32'd0,
   localparam int          SHIFT_W   = adm_shift_w(MAX_SHIFT)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sample_en,
   input  logic               comp_res,
   input  logic               adapt_en,
   output logic [WIDTH-1:0]   counter,
   output logic [SHIFT_W-1:0] step_shift,
   output logic               bit_out,
   output logic               bit_valid,
   output logic               sat
);

   localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

   logic [SHIFT_W-1:0]   shift_n_s;
   logic [SHIFT_W-1:0]   shift_q_s;
   logic [ADM_MAX_W-1:0] acc_s;
   logic [ADM_MAX_W-1:0] step_s;

   logic [WIDTH-1:0] counter_q, counter_d;
   logic             bit_q,     bit_d;
   logic             valid_q,   valid_d;
   logic             sat_q,     sat_d;

   adm_step_ctrl #(
      .RUN_LEN   (RUN_LEN),
      .MAX_SHIFT (MAX_SHIFT)
   ) u_step_ctrl (
      .clk         (clk),
      .rst         (rst),
      .sample_en_i (sample_en),
      .d_i         (comp_res),
      .adapt_en_i  (adapt_en),
      .shift_n_o   (shift_n_s),
      .shift_q_o   (shift_q_s)
   );

   // Next accumulator and pulse outputs. The new exponent applies to this sample.
   always_comb begin
      acc_s     = ADM_MAX_W'(counter_q);
      step_s    = ADM_ONE << shift_n_s;
      counter_d = counter_q;
      bit_d     = bit_q;
      valid_d   = 1'b0;
      sat_d     = 1'b0;
      if (sample_en) begin
         counter_d = WIDTH'(adm_clamp_addsub(acc_s, step_s, comp_res, WIDTH));
         sat_d     = adm_clamp_hit(acc_s, step_s, comp_res, WIDTH);
         bit_d     = comp_res;
         valid_d   = 1'b1;
      end else begin
         counter_d = counter_q;
         bit_d     = bit_q;
         valid_d   = 1'b0;
         sat_d     = 1'b0;
      end
   end

   // Accumulator and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter_q <= INIT_VAL;
         bit_q     <= 1'b0;
         valid_q   <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         counter_q <= counter_d;
         bit_q     <= bit_d;
         valid_q   <= valid_d;
         sat_q     <= sat_d;
      end
   end

   assign counter    = counter_q;
   assign step_shift = shift_q_s;
   assign bit_out    = bit_q;
   assign bit_valid  = valid_q;
   assign sat        = sat_q;

endmodule

// File: tb/tb_adaptive_delta_mod.sv
// Testbench for adaptive_delta_mod with WIDTH=8, RUN_LEN=3, MAX_SHIFT=4, INIT=0.
// Directed vectors with hand-computed expectations, plus hand-written
// sequences for async reset, the long legacy ramp and sample gaps.
module tb_adaptive_delta_mod;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sample_en = 1'b0;
   logic       comp_res = 1'b0;
   logic       adapt_en = 1'b0;
   logic [7:0] counter;
   logic [2:0] step_shift;
   logic       bit_out;
   logic       bit_valid;
   logic       sat;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       pre_rst;
      logic       se;
      logic       d;
      logic       ae;
      logic [7:0] cnt;
      logic [2:0] sh;
      logic       bo;
      logic       bv;
      logic       st;
   } vec_t;

   vec_t vecs[$];

   adaptive_delta_mod #(
      .WIDTH     (8),
      .RUN_LEN   (3),
      .MAX_SHIFT (4),
      .INIT      (32'd0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sample_en  (sample_en),
      .comp_res   (comp_res),
      .adapt_en   (adapt_en),
      .counter    (counter),
      .step_shift (step_shift),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .sat        (sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] cnt, input logic [2:0] sh,
                          input logic bo, input logic bv, input logic st);
      chk({tag, "_cnt"},   {24'd0, counter},    {24'd0, cnt});
      chk({tag, "_shift"}, {29'd0, step_shift}, {29'd0, sh});
      chk({tag, "_bit"},   {31'd0, bit_out},    {31'd0, bo});
      chk({tag, "_valid"}, {31'd0, bit_valid},  {31'd0, bv});
      chk({tag, "_sat"},   {31'd0, sat},        {31'd0, st});
   endtask

   // Drive one cycle's inputs at the falling edge, look after the rising edge.
   task automatic step(input logic se, input logic d, input logic ae);
      @(negedge clk);
      sample_en = se;
      comp_res  = d;
      adapt_en  = ae;
      @(posedge clk);
      #1;
   endtask

   // Raise reset between clock edges and check that outputs clear at once.
   task automatic async_reset(input string tag);
      @(posedge clk);
      #2;
      sample_en = 1'b0;
      rst = 1'b1;
      #1;
      chk_all(tag, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic add(input logic pr, input logic se, input logic d, input logic ae,
                      input logic [7:0] cnt, input logic [2:0] sh,
                      input logic bo, input logic bv, input logic st);
      vec_t v;
      v.pre_rst = pr; v.se = se; v.d = d; v.ae = ae;
      v.cnt = cnt; v.sh = sh; v.bo = bo; v.bv = bv; v.st = st;
      vecs.push_back(v);
   endtask

   initial begin
      // Adaptive ramp from reset: shift 0,0,1,2,3,4,4.
      add(1'b1, 1'b1, 1'b1, 1'b1, 8'd1,  3'd0, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 8'd2,  3'd0, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 8'd4,  3'd1, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 8'd8,  3'd2, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 8'd16, 3'd3, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 8'd32, 3'd4, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 8'd48, 3'd4, 1'b1, 1'b1, 1'b0);
      // Reversals shrink the step.
      add(1'b0, 1'b1, 1'b0, 1'b1, 8'd40, 3'd3, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 8'd44, 3'd2, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 8'd42, 3'd1, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 8'd43, 3'd0, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 8'd42, 3'd0, 1'b0, 1'b1, 1'b0);
      // Idle cycle: hold, no pulses.
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd42, 3'd0, 1'b0, 1'b0, 1'b0);
      // Preload counter 7 with fixed steps, then step down to 6.
      add(1'b1, 1'b1, 1'b1, 1'b0, 8'd1,  3'd0, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 8'd2,  3'd0, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 8'd3,  3'd0, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 8'd4,  3'd0, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 8'd5,  3'd0, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 8'd6,  3'd0, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 8'd7,  3'd0, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'd6,  3'd0, 1'b0, 1'b1, 1'b0);
      // Downward run: steps 1,2,4 from 6; the last one clamps at 0 from 3.
      add(1'b0, 1'b1, 1'b0, 1'b1, 8'd5,  3'd0, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 8'd3,  3'd1, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 8'd0,  3'd2, 1'b0, 1'b1, 1'b1);
      // Reversal from shift 2 -> 1, step 2.
      add(1'b0, 1'b1, 1'b1, 1'b1, 8'd2,  3'd1, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 8'd4,  3'd1, 1'b1, 1'b1, 1'b0);
      // adapt_en dropped: step 1 this sample, run length keeps counting.
      add(1'b0, 1'b1, 1'b1, 1'b0, 8'd5,  3'd0, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 8'd7,  3'd1, 1'b1, 1'b1, 1'b0);

      // Reset asserted between edges, before any clock edge.
      #3;
      rst = 1'b1;
      #1;
      chk_all("rst0", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Legacy fixed-step ramp into the upper bound.
      for (int i = 1; i <= 260; i++) begin
         step(1'b1, 1'b1, 1'b0);
         chk($sformatf("leg%0d_cnt", i), {24'd0, counter}, (i > 255) ? 32'd255 : i);
         chk($sformatf("leg%0d_sat", i), {31'd0, sat}, (i > 255) ? 32'd1 : 32'd0);
         chk($sformatf("leg%0d_valid", i), {31'd0, bit_valid}, 32'd1);
      end

      // Table vectors.
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].pre_rst) begin
            async_reset($sformatf("vrst%0d", i));
         end
         step(vecs[i].se, vecs[i].d, vecs[i].ae);
         chk_all($sformatf("v%0d", i), vecs[i].cnt, vecs[i].sh, vecs[i].bo, vecs[i].bv, vecs[i].st);
      end

      // Gap: ten idle cycles hold everything and produce no pulses.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 1'b1);
         chk_all($sformatf("gap%0d", i), 8'd7, 3'd1, 1'b1, 1'b0, 1'b0);
      end

      // Mid-run reset, then first sample compares against prev=0.
      async_reset("rst_mid");
      step(1'b1, 1'b1, 1'b1);
      chk_all("post_rst", 8'd1, 3'd0, 1'b1, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
